// File: rtl/secded_monitor_top.sv
// Hamming SECDED receive monitor: strobe-captured decode, saturating SEC/DED counters, scanned 7-seg readout.
// Optional SECDED_DEBOUNCE_EN adds a DEB_CYCLES stability filter on the synchronised strobe.
`timescale 1ns/1ps
module secded_monitor_top #(
  parameter int DATA_W      = 4,
  parameter int N_DIGITS    = 4,
  parameter int CNT_W       = 16,
  parameter int REFRESH_DIV = 50000,
  parameter int DEB_CYCLES  = 500000,
  localparam int P_W        = (DATA_W <= 4) ? 3 : (DATA_W <= 11) ? 4 : 5,
  localparam int CODE_W     = DATA_W + P_W + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   data_i,
  input  logic [CODE_W-1:0]   code_rx_i,
  input  logic                sample_i,
  input  logic                clr_cnt_i,
  input  logic [1:0]          mode_i,
  output logic [6:0]          seg,
  output logic [N_DIGITS-1:0] an,
  output logic [DATA_W-1:0]   led_out,
  output logic                led_sec,
  output logic                led_ded,
  output logic                led_mismatch
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int NIB_W = 4 * N_DIGITS;

  // j-th data bit lives at the j-th non-power-of-two position (3,5,6,7,9,...)
  function automatic int dpos(input int j);
    int k;
    int r;
    k = 0;
    r = 0;
    for (int i = 3; i < 64; i++) begin
      if ((i & (i - 1)) != 0) begin
        if (k == j) r = i;
        k++;
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  logic r_s1, r_s2, r_prev;
  logic [1:0] r_m1, r_m2;
  logic w_lvl, w_rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_prev <= 1'b0;
      r_m1   <= 2'd0;
      r_m2   <= 2'd0;
    end else begin
      r_s1   <= sample_i;
      r_s2   <= r_s1;
      r_prev <= w_lvl;
      r_m1   <= mode_i;
      r_m2   <= r_m1;
    end
  end

`ifdef SECDED_DEBOUNCE_EN
  localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
  logic [DEB_W-1:0] r_deb_cnt;
  logic             r_deb;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_deb_cnt <= '0;
      r_deb     <= 1'b0;
    end else if (r_s2 == r_deb) begin
      r_deb_cnt <= '0;
    end else if (r_deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
      r_deb_cnt <= '0;
      r_deb     <= r_s2;
    end else begin
      r_deb_cnt <= r_deb_cnt + 1'b1;
    end
  end

  assign w_lvl = r_deb;
`else
  assign w_lvl = r_s2;
`endif

  assign w_rise = w_lvl & ~r_prev;

  logic [P_W-1:0]    w_syn;
  logic              w_pg, w_single, w_double;
  logic [CODE_W-1:0] w_fix;
  logic [DATA_W-1:0] w_dec;

  always_comb begin
    w_syn = '0;
    w_pg  = ^code_rx_i;
    for (int i = 1; i < CODE_W; i++) begin
      if (code_rx_i[i]) w_syn = w_syn ^ P_W'(i);
    end
    w_single = w_pg && (32'(w_syn) < 32'(CODE_W));
    w_double = (!w_pg && (w_syn != '0)) || (w_pg && !w_single);
    w_fix = code_rx_i;
    for (int i = 0; i < CODE_W; i++) begin
      if (w_single && (32'(w_syn) == 32'(i))) w_fix[i] = ~code_rx_i[i];
    end
    w_dec = '0;
    for (int j = 0; j < DATA_W; j++) begin
      w_dec[j] = w_fix[dpos(j)];
    end
  end

  logic [DATA_W-1:0] r_led_out;
  logic              r_sec, r_ded, r_mis, r_valid;
  logic [P_W-1:0]    r_syn;
  logic [CNT_W-1:0]  r_sec_cnt, r_ded_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_led_out <= '0;
      r_sec     <= 1'b0;
      r_ded     <= 1'b0;
      r_mis     <= 1'b0;
      r_valid   <= 1'b0;
      r_syn     <= '0;
      r_sec_cnt <= '0;
      r_ded_cnt <= '0;
    end else begin
      if (w_rise) begin
        r_led_out <= w_dec;
        r_sec     <= w_single;
        r_ded     <= w_double;
        r_mis     <= (w_dec != data_i);
        r_syn     <= w_syn;
        r_valid   <= 1'b1;
      end
      // a clear wins over a same-cycle event, which is then lost
      if (clr_cnt_i) begin
        r_sec_cnt <= '0;
        r_ded_cnt <= '0;
      end else if (w_rise) begin
        if (w_single && (r_sec_cnt != '1)) r_sec_cnt <= r_sec_cnt + 1'b1;
        if (w_double && (r_ded_cnt != '1)) r_ded_cnt <= r_ded_cnt + 1'b1;
      end
    end
  end

  logic [REF_W-1:0] r_ref;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  logic [1:0]       r_mode, w_mode_nxt;
  logic             w_wrap;
  logic [6:0]       r_seg;
  logic [N_DIGITS-1:0] r_an;

  assign w_wrap     = (r_ref == REF_W'(REFRESH_DIV - 1));
  assign w_mode_nxt = w_wrap ? r_m2 : r_mode;
  assign w_idx_nxt  = !w_wrap ? r_idx :
                      (r_idx == IDX_W'(N_DIGITS - 1)) ? '0 : r_idx + 1'b1;

  logic [NIB_W-1:0] w_dat_ext, w_sec_ext, w_ded_ext;
  logic [7:0]       w_syn_ext;
  logic [3:0]       w_nib, w_stat;
  logic             w_blank, w_dash;

  always_comb begin
    w_dat_ext = '0;
    w_dat_ext[DATA_W-1:0] = r_led_out;
    w_sec_ext = '0;
    w_sec_ext[CNT_W-1:0] = r_sec_cnt;
    w_ded_ext = '0;
    w_ded_ext[CNT_W-1:0] = r_ded_cnt;
    w_syn_ext = '0;
    w_syn_ext[P_W-1:0] = r_syn;
    w_stat  = r_ded ? 4'hD : (r_sec ? 4'h5 : 4'h0);
    w_nib   = 4'h0;
    w_blank = 1'b0;
    w_dash  = 1'b0;
    case (w_mode_nxt)
      2'd0: begin
        if (32'(w_idx_nxt) >= 32'((DATA_W + 3) / 4)) w_blank = 1'b1;
        else if (!r_valid) w_dash = 1'b1;
        else w_nib = w_dat_ext[32'(w_idx_nxt) * 4 +: 4];
      end
      2'd1: begin
        if (32'(w_idx_nxt) > 32'd2) w_blank = 1'b1;
        else if (!r_valid) w_dash = 1'b1;
        else if (w_idx_nxt == IDX_W'(0)) w_nib = w_syn_ext[3:0];
        else if (w_idx_nxt == IDX_W'(1)) w_nib = w_syn_ext[7:4];
        else w_nib = w_stat;
      end
      2'd2:    w_nib = w_sec_ext[32'(w_idx_nxt) * 4 +: 4];
      default: w_nib = w_ded_ext[32'(w_idx_nxt) * 4 +: 4];
    endcase
  end

  // seg/an are computed from the slot being entered so they switch together
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ref  <= '0;
      r_idx  <= '0;
      r_mode <= 2'd0;
      r_seg  <= 7'h7F;
      r_an   <= '1;
    end else begin
      r_ref  <= w_wrap ? '0 : r_ref + 1'b1;
      r_idx  <= w_idx_nxt;
      r_mode <= w_mode_nxt;
      r_seg  <= w_blank ? 7'h7F : (w_dash ? 7'h3F : hex7(w_nib));
      r_an   <= ~(N_DIGITS'(1) << w_idx_nxt);
    end
  end

  assign seg          = r_seg;
  assign an           = r_an;
  assign led_out      = r_led_out;
  assign led_sec      = r_sec;
  assign led_ded      = r_ded;
  assign led_mismatch = r_mis;

endmodule

// File: tb/tb_secded_monitor_top.sv
// Directed bench: 4-bit instance with a fast scan and 2-bit counters, plus an 11-bit instance for wide correction.
`timescale 1ns/1ps
module tb_secded_monitor_top;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] data_a;
  logic [7:0] code_a;
  logic       sample_a, clr_a;
  logic [1:0] mode_a;
  logic [6:0] seg_a;
  logic [3:0] an_a;
  logic [3:0] led_out_a;
  logic       sec_a, ded_a, mis_a;

  logic [10:0] data_b;
  logic [15:0] code_b;
  logic        sample_b;
  logic [6:0]  seg_b;
  logic [3:0]  an_b;
  logic [10:0] led_out_b;
  logic        sec_b, ded_b, mis_b;

  int n_tests = 0;
  int n_fail  = 0;
  logic [6:0] s;

  always #5 clk = ~clk;

  secded_monitor_top #(.DATA_W(4), .N_DIGITS(4), .CNT_W(2), .REFRESH_DIV(4), .DEB_CYCLES(4)) dut_a (
    .clk(clk), .rst(rst), .data_i(data_a), .code_rx_i(code_a), .sample_i(sample_a),
    .clr_cnt_i(clr_a), .mode_i(mode_a), .seg(seg_a), .an(an_a), .led_out(led_out_a),
    .led_sec(sec_a), .led_ded(ded_a), .led_mismatch(mis_a));

  secded_monitor_top #(.DATA_W(11), .N_DIGITS(4), .CNT_W(16), .REFRESH_DIV(4), .DEB_CYCLES(4)) dut_b (
    .clk(clk), .rst(rst), .data_i(data_b), .code_rx_i(code_b), .sample_i(sample_b),
    .clr_cnt_i(1'b0), .mode_i(2'd0), .seg(seg_b), .an(an_b), .led_out(led_out_b),
    .led_sec(sec_b), .led_ded(ded_b), .led_mismatch(mis_b));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic press_a(input logic [7:0] code, input logic [3:0] dat, input logic clr);
    @(negedge clk);
    code_a = code; data_a = dat; sample_a = 1'b1;
    repeat (2) @(negedge clk);
    clr_a = clr;
    @(negedge clk);
    clr_a = 1'b0; sample_a = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic set_mode(input logic [1:0] m);
    mode_a = m;
    repeat (24) @(negedge clk);
  endtask

  // waits for digit idx to be driven; on timeout returns X so the next check fails
  task automatic read_digit(input int idx, output logic [6:0] sv);
    logic [3:0] want;
    logic       hit;
    want = ~(4'b0001 << idx);
    hit  = 1'b0;
    for (int c = 0; c < 40 && !hit; c++) begin
      @(negedge clk);
      if (an_a === want) hit = 1'b1;
    end
    sv = hit ? seg_a : 7'bx;
  endtask

  initial begin
    rst = 1'b1; data_a = 4'h0; code_a = 8'h00; sample_a = 1'b0; clr_a = 1'b0; mode_a = 2'd0;
    data_b = 11'h0; code_b = 16'h0; sample_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_seg", 32'(seg_a), 32'h7F);
    chk("rst_an", 32'(an_a), 32'hF);
    chk("rst_led_out", 32'(led_out_a), 32'h0);
    chk("rst_flags", {29'd0, sec_a, ded_a, mis_a}, 32'h0);

    rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      int idx;
      @(negedge clk);
      idx = (k < 4) ? 0 : ((k / 4) % 4);
      chk("scan_an", 32'(an_a), 32'((~(4'b0001 << idx)) & 4'hF));
      if (k == 1) chk("dash_before_capture", 32'(seg_a), 32'h3F);
    end

    // 4'hB encodes to 8'hAA; leds must move on the 3rd edge, not before
    @(negedge clk);
    code_a = 8'hAA; data_a = 4'hB; sample_a = 1'b1;
    repeat (2) @(negedge clk);
    chk("latency_2_edges", 32'(led_out_a), 32'h0);
    @(negedge clk);
    chk("latency_3_edges", 32'(led_out_a), 32'hB);
    sample_a = 1'b0;
    repeat (4) @(negedge clk);
    chk("t1_flags", {29'd0, sec_a, ded_a, mis_a}, 32'h0);
    read_digit(0, s); chk("t1_mode0_d0", 32'(s), 32'h03);
    read_digit(1, s); chk("t1_mode0_d1_blank", 32'(s), 32'h7F);
    set_mode(2'd1);
    read_digit(2, s); chk("t1_status", 32'(s), 32'h40);
    read_digit(0, s); chk("t1_syn", 32'(s), 32'h40);

    press_a(8'h8A, 4'hB, 1'b0);
    chk("t2_led_out", 32'(led_out_a), 32'hB);
    chk("t2_flags", {29'd0, sec_a, ded_a, mis_a}, 32'b100);
    read_digit(0, s); chk("t2_syn_lo", 32'(s), 32'h12);
    read_digit(1, s); chk("t2_syn_hi", 32'(s), 32'h40);
    read_digit(2, s); chk("t2_status", 32'(s), 32'h12);
    set_mode(2'd2);
    read_digit(0, s); chk("t2_sec_cnt_d0", 32'(s), 32'h79);
    read_digit(1, s); chk("t2_sec_cnt_d1", 32'(s), 32'h40);

    press_a(8'hE2, 4'hB, 1'b0);
    chk("t3_led_out", 32'(led_out_a), 32'hE);
    chk("t3_flags", {29'd0, sec_a, ded_a, mis_a}, 32'b011);
    read_digit(0, s); chk("t3_sec_cnt", 32'(s), 32'h79);
    set_mode(2'd3);
    read_digit(0, s); chk("t3_ded_cnt", 32'(s), 32'h79);
    set_mode(2'd1);
    read_digit(2, s); chk("t3_status", 32'(s), 32'h21);

    press_a(8'hAB, 4'hB, 1'b0);
    chk("t4_led_out", 32'(led_out_a), 32'hB);
    chk("t4_flags", {29'd0, sec_a, ded_a, mis_a}, 32'b100);
    read_digit(0, s); chk("t4_syn0", 32'(s), 32'h40);
    for (int n = 0; n < 3; n++) press_a(8'h8A, 4'hB, 1'b0);
    set_mode(2'd2);
    read_digit(0, s); chk("t4_sec_sat", 32'(s), 32'h30);
    read_digit(1, s); chk("t4_sec_upper", 32'(s), 32'h40);

    press_a(8'hE2, 4'hB, 1'b1);
    chk("t6_led_ded", {30'd0, sec_a, ded_a}, 32'b01);
    chk("t6_led_out", 32'(led_out_a), 32'hE);
    read_digit(0, s); chk("t6_sec_cleared", 32'(s), 32'h40);
    set_mode(2'd3);
    read_digit(0, s); chk("t6_ded_cleared", 32'(s), 32'h40);
    set_mode(2'd0);
    read_digit(0, s); chk("t6_mode0_d0", 32'(s), 32'h06);

    // 11-bit all-ones encodes to 16'hFFFF; flip position 9
    @(negedge clk);
    code_b = 16'hFDFF; data_b = 11'h7FF; sample_b = 1'b1;
    repeat (3) @(negedge clk);
    sample_b = 1'b0;
    repeat (4) @(negedge clk);
    chk("w11_led_out", 32'(led_out_b), 32'h7FF);
    chk("w11_flags", {29'd0, sec_b, ded_b, mis_b}, 32'b100);

    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midscan_rst_an", 32'(an_a), 32'hF);
    chk("midscan_rst_seg", 32'(seg_a), 32'h7F);
    chk("midscan_rst_led", 32'(led_out_a), 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
